// File: rtl/spu_regfile_bypass.sv
// Dual-pipe SPU register file with registered reads, optional same-cycle write forwarding,
// and a per-register pending-write scoreboard used by issue to detect RAW hazards.
module spu_regfile_bypass #(
    parameter int NUM_REGS  = 128,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int RD_PORTS  = 3,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_even,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_odd,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data_even,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data_odd,
    output logic [RD_PORTS-1:0]          hazard_even,
    output logic [RD_PORTS-1:0]          hazard_odd,
    input  logic                         wr_en_even,
    input  logic [ADDR_W-1:0]            wr_addr_even,
    input  logic [DATA_W-1:0]            wr_data_even,
    input  logic                         wr_en_odd,
    input  logic [ADDR_W-1:0]            wr_addr_odd,
    input  logic [DATA_W-1:0]            wr_data_odd,
    input  logic                         rsv_en_even,
    input  logic [ADDR_W-1:0]            rsv_addr_even,
    input  logic                         rsv_en_odd,
    input  logic [ADDR_W-1:0]            rsv_addr_odd,
    output logic                         wr_conflict
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]          regs_q [NUM_REGS];
    logic [DATA_W-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [RD_PORTS*DATA_W-1:0] rd_data_even_q, rd_data_even_d;
    logic [RD_PORTS*DATA_W-1:0] rd_data_odd_q, rd_data_odd_d;
    logic                       wr_conflict_q, wr_conflict_d;

    logic wr_ok_even, wr_ok_odd, rsv_ok_even, rsv_ok_odd;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    // Odd pipe is checked first so it wins when both pipes write the read address.
    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (in_range(a)) begin
            v = regs_q[a];
            if (BYPASS_EN) begin
                if (wr_ok_odd && wr_addr_odd == a) begin
                    v = wr_data_odd;
                end else if (wr_ok_even && wr_addr_even == a) begin
                    v = wr_data_even;
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        wr_ok_even  = wr_en_even && in_range(wr_addr_even);
        wr_ok_odd   = wr_en_odd && in_range(wr_addr_odd);
        rsv_ok_even = rsv_en_even && in_range(rsv_addr_even);
        rsv_ok_odd  = rsv_en_odd && in_range(rsv_addr_odd);
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_ok_even) regs_d[wr_addr_even] = wr_data_even;
        if (wr_ok_odd)  regs_d[wr_addr_odd]  = wr_data_odd;
        wr_conflict_d = wr_ok_even && wr_ok_odd && (wr_addr_even == wr_addr_odd);
    end

    // Clears are applied before sets so a new reservation owns the register.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok_even)  busy_d[wr_addr_even]  = 1'b0;
        if (wr_ok_odd)   busy_d[wr_addr_odd]   = 1'b0;
        if (rsv_ok_even) busy_d[rsv_addr_even] = 1'b1;
        if (rsv_ok_odd)  busy_d[rsv_addr_odd]  = 1'b1;
    end

    always_comb begin
        rd_data_even_d = '0;
        rd_data_odd_d  = '0;
        hazard_even    = '0;
        hazard_odd     = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_data_even_d[i*DATA_W +: DATA_W] = read_value(rd_addr_even[i*ADDR_W +: ADDR_W]);
            rd_data_odd_d[i*DATA_W +: DATA_W]  = read_value(rd_addr_odd[i*ADDR_W +: ADDR_W]);
            hazard_even[i] = in_range(rd_addr_even[i*ADDR_W +: ADDR_W]) &&
                             busy_q[rd_addr_even[i*ADDR_W +: ADDR_W]];
            hazard_odd[i]  = in_range(rd_addr_odd[i*ADDR_W +: ADDR_W]) &&
                             busy_q[rd_addr_odd[i*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q         <= '0;
            rd_data_even_q <= '0;
            rd_data_odd_q  <= '0;
            wr_conflict_q  <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            busy_q         <= busy_d;
            rd_data_even_q <= rd_data_even_d;
            rd_data_odd_q  <= rd_data_odd_d;
            wr_conflict_q  <= wr_conflict_d;
        end
    end

    assign rd_data_even = rd_data_even_q;
    assign rd_data_odd  = rd_data_odd_q;
    assign wr_conflict  = wr_conflict_q;

endmodule

// File: tb/tb_spu_regfile_bypass.sv
// Scoreboard bench: a forwarding instance (128 regs) and a non-forwarding instance (100 regs)
// share all inputs; a reference model predicts reads, hazards and conflicts for both.
module tb_spu_regfile_bypass;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [20:0]  rd_addr_even, rd_addr_odd;
    logic         wr_en_even, wr_en_odd, rsv_en_even, rsv_en_odd;
    logic [6:0]   wr_addr_even, wr_addr_odd, rsv_addr_even, rsv_addr_odd;
    logic [127:0] wr_data_even, wr_data_odd;

    logic [383:0] rde_bp, rdo_bp, rde_nb, rdo_nb;
    logic [2:0]   hze_bp, hzo_bp, hze_nb, hzo_nb;
    logic         wc_bp, wc_nb;

    int tests = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0][1:0][2:0][127:0] rd;
        logic [1:0]                  conf;
    } exp_t;
    exp_t expQ[$];

    logic [127:0] mregs [2][128];
    logic         mbusy [2][128];
    int           lim [2];

    localparam logic [127:0] VAL_A  = {16'h000A, 112'h0};
    localparam logic [127:0] VAL_C  = {16'h000C, 112'h0};
    localparam logic [127:0] VAL_11 = {16{8'h11}};
    localparam logic [127:0] VAL_22 = {16{8'h22}};

    spu_regfile_bypass dut_bp (
        .clk(clk), .reset(reset),
        .rd_addr_even(rd_addr_even), .rd_addr_odd(rd_addr_odd),
        .rd_data_even(rde_bp), .rd_data_odd(rdo_bp),
        .hazard_even(hze_bp), .hazard_odd(hzo_bp),
        .wr_en_even(wr_en_even), .wr_addr_even(wr_addr_even), .wr_data_even(wr_data_even),
        .wr_en_odd(wr_en_odd), .wr_addr_odd(wr_addr_odd), .wr_data_odd(wr_data_odd),
        .rsv_en_even(rsv_en_even), .rsv_addr_even(rsv_addr_even),
        .rsv_en_odd(rsv_en_odd), .rsv_addr_odd(rsv_addr_odd),
        .wr_conflict(wc_bp)
    );

    spu_regfile_bypass #(.NUM_REGS(100), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_addr_even(rd_addr_even), .rd_addr_odd(rd_addr_odd),
        .rd_data_even(rde_nb), .rd_data_odd(rdo_nb),
        .hazard_even(hze_nb), .hazard_odd(hzo_nb),
        .wr_en_even(wr_en_even), .wr_addr_even(wr_addr_even), .wr_data_even(wr_data_even),
        .wr_en_odd(wr_en_odd), .wr_addr_odd(wr_addr_odd), .wr_data_odd(wr_data_odd),
        .rsv_en_even(rsv_en_even), .rsv_addr_even(rsv_addr_even),
        .rsv_en_odd(rsv_en_odd), .rsv_addr_odd(rsv_addr_odd),
        .wr_conflict(wc_nb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [383:0] dutRd(input int d, input int p);
        if (d == 0) return (p == 0) ? rde_bp : rdo_bp;
        return (p == 0) ? rde_nb : rdo_nb;
    endfunction

    function automatic logic [2:0] dutHz(input int d, input int p);
        if (d == 0) return (p == 0) ? hze_bp : hzo_bp;
        return (p == 0) ? hze_nb : hzo_nb;
    endfunction

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 128; r++) begin
                mregs[d][r] = '0;
                mbusy[d][r] = 1'b0;
            end
        end
    endtask

    task automatic clearInputs();
        wr_en_even = 0; wr_en_odd = 0; rsv_en_even = 0; rsv_en_odd = 0;
        wr_addr_even = '0; wr_addr_odd = '0; rsv_addr_even = '0; rsv_addr_odd = '0;
        wr_data_even = '0; wr_data_odd = '0;
    endtask

    task automatic setReads(input logic [6:0] e0, e1, e2, o0, o1, o2);
        rd_addr_even = {e2, e1, e0};
        rd_addr_odd  = {o2, o1, o0};
    endtask

    task automatic checkResetZero(input string tag);
        logic [383:0] rd;
        logic [2:0]   hz;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                rd = dutRd(d, p);
                hz = dutHz(d, p);
                checkOutput($sformatf("%s_rd_d%0d_p%0d", tag, d, p), rd[127:0] | rd[255:128] | rd[383:256], '0);
                checkOutput($sformatf("%s_hz_d%0d_p%0d", tag, d, p), {125'b0, hz}, '0);
            end
        end
        checkOutput({tag, "_wc_bp"}, {127'b0, wc_bp}, '0);
        checkOutput({tag, "_wc_nb"}, {127'b0, wc_nb}, '0);
    endtask

    task automatic compareHead();
        exp_t         e;
        logic [383:0] rd;
        if (expQ.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL queue_empty got=0 exp=1");
            return;
        end
        e = expQ.pop_front();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                rd = dutRd(d, p);
                for (int i = 0; i < 3; i++) begin
                    checkOutput($sformatf("rd_d%0d_p%0d_%0d", d, p, i), rd[i*128 +: 128], e.rd[d][p][i]);
                end
            end
        end
        checkOutput("wc_bp", {127'b0, wc_bp}, {127'b0, e.conf[0]});
        checkOutput("wc_nb", {127'b0, wc_nb}, {127'b0, e.conf[1]});
    endtask

    // Drives one cycle: check hazards, predict next-cycle outputs, advance model, compare.
    task automatic applyStimulus();
        exp_t         e;
        logic [6:0]   a;
        logic [127:0] v;
        logic [2:0]   hz;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                hz = dutHz(d, p);
                for (int i = 0; i < 3; i++) begin
                    a = (p == 1) ? rd_addr_odd[i*7 +: 7] : rd_addr_even[i*7 +: 7];
                    checkOutput($sformatf("hz_d%0d_p%0d_%0d", d, p, i), {127'b0, hz[i]},
                                {127'b0, (int'(a) < lim[d]) && mbusy[d][a]});
                    v = '0;
                    if (int'(a) < lim[d]) begin
                        v = mregs[d][a];
                        if (d == 0 && wr_en_odd && wr_addr_odd == a) v = wr_data_odd;
                        else if (d == 0 && wr_en_even && wr_addr_even == a) v = wr_data_even;
                    end
                    e.rd[d][p][i] = v;
                end
            end
            e.conf[d] = wr_en_even && wr_en_odd && (wr_addr_even == wr_addr_odd) &&
                        (int'(wr_addr_even) < lim[d]);
        end
        expQ.push_back(e);
        for (int d = 0; d < 2; d++) begin
            if (wr_en_even && int'(wr_addr_even) < lim[d]) begin
                mregs[d][wr_addr_even] = wr_data_even;
                mbusy[d][wr_addr_even] = 1'b0;
            end
            if (wr_en_odd && int'(wr_addr_odd) < lim[d]) begin
                mregs[d][wr_addr_odd] = wr_data_odd;
                mbusy[d][wr_addr_odd] = 1'b0;
            end
            if (rsv_en_even && int'(rsv_addr_even) < lim[d]) mbusy[d][rsv_addr_even] = 1'b1;
            if (rsv_en_odd && int'(rsv_addr_odd) < lim[d])   mbusy[d][rsv_addr_odd]  = 1'b1;
        end
        @(posedge clk);
        #1;
        compareHead();
    endtask

    function automatic logic [6:0] randAddr();
        if ($urandom_range(0, 1) == 1) return 7'($urandom_range(0, 15));
        return 7'($urandom_range(95, 127));
    endfunction

    initial begin
        lim[0] = 128;
        lim[1] = 100;
        clearModel();
        clearInputs();
        setReads(7'h05, 7'h7F, 7'h05, 7'h7F, 7'h05, 7'h7F);
        repeat (2) @(posedge clk);
        #2;
        checkResetZero("rst");
        @(negedge clk);
        reset = 1'b1;

        applyStimulus();

        // Plain write then read from both pipes.
        wr_en_even = 1; wr_addr_even = 7'd5; wr_data_even = VAL_A;
        applyStimulus();
        clearInputs();
        setReads(7'd5, 7'd0, 7'd0, 7'd0, 7'd5, 7'd0);
        applyStimulus();

        // Same-cycle write and read of reg 5.
        wr_en_even = 1; wr_addr_even = 7'd5; wr_data_even = VAL_C;
        setReads(7'd0, 7'd0, 7'd0, 7'd5, 7'd0, 7'd0);
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Both pipes write reg 9.
        wr_en_even = 1; wr_addr_even = 7'd9; wr_data_even = VAL_11;
        wr_en_odd  = 1; wr_addr_odd  = 7'd9; wr_data_odd  = VAL_22;
        setReads(7'd9, 7'd9, 7'd5, 7'd9, 7'd0, 7'd0);
        applyStimulus();
        clearInputs();
        applyStimulus();
        applyStimulus();

        // Scoreboard: reserve, retire, then retire and re-reserve together.
        setReads(7'd7, 7'd0, 7'd0, 7'd0, 7'd7, 7'd0);
        rsv_en_odd = 1; rsv_addr_odd = 7'd7;
        applyStimulus();
        clearInputs();
        applyStimulus();
        wr_en_odd = 1; wr_addr_odd = 7'd7; wr_data_odd = 128'h77;
        applyStimulus();
        clearInputs();
        applyStimulus();
        wr_en_even = 1; wr_addr_even = 7'd7; wr_data_even = 128'h78;
        rsv_en_even = 1; rsv_addr_even = 7'd7;
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Addresses beyond the smaller instance's range; dual reservation of one register.
        wr_en_even = 1; wr_addr_even = 7'd120; wr_data_even = 128'hDEAD;
        rsv_en_even = 1; rsv_addr_even = 7'd110;
        rsv_en_odd = 1; rsv_addr_odd = 7'd110;
        setReads(7'd120, 7'd110, 7'd99, 7'd110, 7'd120, 7'd127);
        applyStimulus();
        clearInputs();
        applyStimulus();

        for (int n = 0; n < 60; n++) begin
            wr_en_even = 1'($urandom_range(0, 1)); wr_addr_even = randAddr();
            wr_data_even = {$urandom, $urandom, $urandom, $urandom};
            wr_en_odd = 1'($urandom_range(0, 1)); wr_addr_odd = ($urandom_range(0, 3) == 0) ? wr_addr_even : randAddr();
            wr_data_odd = {$urandom, $urandom, $urandom, $urandom};
            rsv_en_even = 1'($urandom_range(0, 1)); rsv_addr_even = randAddr();
            rsv_en_odd = 1'($urandom_range(0, 1)); rsv_addr_odd = randAddr();
            setReads(randAddr(), randAddr(), wr_addr_even, randAddr(), wr_addr_odd, rsv_addr_even);
            applyStimulus();
        end
        clearInputs();

        // Asynchronous reset in the middle of a cycle.
        wr_en_even = 1; wr_addr_even = 7'd3; wr_data_even = 128'h3333;
        wr_en_odd = 1; wr_addr_odd = 7'd4; wr_data_odd = 128'h4444;
        rsv_en_even = 1; rsv_addr_even = 7'd6;
        applyStimulus();
        clearInputs();
        setReads(7'd3, 7'd4, 7'd6, 7'd4, 7'd3, 7'd6);
        applyStimulus();
        #2;
        reset = 1'b0;
        #1;
        checkResetZero("async");
        clearModel();
        expQ.delete();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus();
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
